aes_key_expander: RTL

- Word-serial AES key schedule generator covering AES-128, AES-192 and AES-256, selected per operation at runtime.
- Produces one 32-bit schedule word per cycle.
- Writes each completed 128-bit round key (addresses 0..Nr) into the round-key store consumed by the cipher datapath.
- Successor to the fixed 128-bit round-key generator. Adds Nk=6/8 schedules, start/busy/done handshake, illegal-mode flagging and mid-operation reset recovery.

---
 rtl/aes_key_expander_if.sv | 26 ++
 rtl/aes_key_expander.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander_if.sv
// Handshake and round-key write bus between the AES key-schedule generator and its user.
// The DUT side uses the slave modport. The driver side uses the master modport.
interface aes_key_expander_if #(
  parameter int unsigned KEY_W  = 256,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic [1:0]        key_size;
  logic [0:KEY_W-1]  key;
  logic              busy;
  logic [127:0]      rk_data;
  logic [ADDR_W-1:0] rk_addr;
  logic              rk_we;
  logic              done;
  logic              err;

  modport master (
    output start, key_size, key,
    input  busy, rk_data, rk_addr, rk_we, done, err
  );

  modport slave (
    input  start, key_size, key,
    output busy, rk_data, rk_addr, rk_we, done, err
  );
endinterface

// File: rtl/aes_key_expander.sv
// Word-serial AES-128/192/256 key schedule: one 32-bit word per cycle, one round key per 4 words.
// The AES-256 schedule is built only when KEY_EXPANDER_AES256_EN is defined.
module aes_key_expander #(
  parameter int unsigned KEY_W  = 256,
  parameter int unsigned ADDR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  aes_key_expander_if.slave  bus
);

`ifdef KEY_EXPANDER_AES256_EN
  localparam int unsigned KEY_WORDS = (KEY_W / 32 < 8) ? KEY_W / 32 : 8;
`else
  localparam int unsigned KEY_WORDS = 6;
`endif
  localparam int unsigned HIST_D = KEY_WORDS;
  localparam int unsigned IDX_W  = 6;

  typedef enum logic [0:0] {IDLE, EXPAND} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  i_q, nwords_q, nwords_c;
  logic [2:0]        j_q, nk_last_c;
  logic [1:0]        ks_q;
  logic [7:0]        rcon_q;
  logic [31:0]       key_q  [0:KEY_WORDS-1];
  logic [31:0]       hist_q [0:HIST_D-1];
  logic [31:0]       asm_q  [0:2];
  logic              busy_q, rk_we_q, done_q, err_q;
  logic [127:0]      rk_data_q;
  logic [ADDR_W-1:0] rk_addr_q;

  logic              legal_c, is_key_c, last_word_c;
  logic [31:0]       back_c, sub_in_c, sub_out_c, t_c, w_c;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

`ifndef KEY_EXPANDER_AES256_EN
  logic key_tail_unused;
  assign key_tail_unused = ^bus.key[KEY_WORDS*32:KEY_W-1];
`endif

  // key_size decode for the start request
  always_comb begin
    legal_c  = (bus.key_size == 2'd0) || (bus.key_size == 2'd1);
`ifdef KEY_EXPANDER_AES256_EN
    legal_c  = legal_c || (bus.key_size == 2'd2);
`endif
    nwords_c = IDX_W'(44);
    case (bus.key_size)
      2'd1:    nwords_c = IDX_W'(52);
      2'd2:    nwords_c = IDX_W'(60);
      default: nwords_c = IDX_W'(44);
    endcase
  end

  // Next schedule word from the latched key or the history window
  always_comb begin
    back_c    = hist_q[3];
    nk_last_c = 3'd3;
    case (ks_q)
      2'd1: begin
        back_c    = hist_q[5];
        nk_last_c = 3'd5;
      end
`ifdef KEY_EXPANDER_AES256_EN
      2'd2: begin
        back_c    = hist_q[7];
        nk_last_c = 3'd7;
      end
`endif
      default: ;
    endcase

    is_key_c    = (i_q <= IDX_W'(nk_last_c));
    last_word_c = (i_q == nwords_q - IDX_W'(1));
    sub_in_c    = (j_q == 3'd0) ? {hist_q[0][23:0], hist_q[0][31:24]} : hist_q[0];
    sub_out_c   = sub_word(sub_in_c);

    t_c = hist_q[0];
    if (j_q == 3'd0) begin
      t_c = sub_out_c ^ {rcon_q, 24'h000000};
    end
`ifdef KEY_EXPANDER_AES256_EN
    else if (ks_q == 2'd2 && j_q == 3'd4) begin
      t_c = sub_out_c;
    end
`endif

    w_c = is_key_c ? key_q[j_q] : (back_c ^ t_c);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && legal_c) state_d = EXPAND;
      EXPAND:  if (i_q == nwords_q)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word 0 is taken straight from the key port in the start cycle so round key 0 lands 4 cycles later
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q       <= '0;
      nwords_q  <= '0;
      j_q       <= '0;
      ks_q      <= '0;
      rcon_q    <= '0;
      busy_q    <= 1'b0;
      rk_we_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rk_data_q <= '0;
      rk_addr_q <= '0;
      for (int k = 0; k < KEY_WORDS; k++) key_q[k]  <= '0;
      for (int k = 0; k < HIST_D; k++)    hist_q[k] <= '0;
      for (int k = 0; k < 3; k++)         asm_q[k]  <= '0;
    end else begin
      rk_we_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= (state_d == EXPAND);
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (legal_c) begin
              ks_q      <= bus.key_size;
              nwords_q  <= nwords_c;
              rcon_q    <= 8'h01;
              for (int k = 0; k < KEY_WORDS; k++) key_q[k] <= bus.key[k*32 +: 32];
              hist_q[0] <= bus.key[0:31];
              asm_q[0]  <= bus.key[0:31];
              i_q       <= IDX_W'(1);
              j_q       <= 3'd1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        EXPAND: begin
          if (i_q != nwords_q) begin
            hist_q[0] <= w_c;
            for (int k = 1; k < HIST_D; k++) hist_q[k] <= hist_q[k-1];
            i_q <= i_q + IDX_W'(1);
            j_q <= (j_q == nk_last_c) ? 3'd0 : j_q + 3'd1;
            if (!is_key_c && j_q == 3'd0) rcon_q <= xtime(rcon_q);
            if (i_q[1:0] == 2'd3) begin
              rk_we_q   <= 1'b1;
              rk_addr_q <= ADDR_W'(i_q >> 2);
              rk_data_q <= {asm_q[0], asm_q[1], asm_q[2], w_c};
            end else begin
              asm_q[i_q[1:0]] <= w_c;
            end
            if (last_word_c) done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.rk_we   = rk_we_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.rk_data = rk_data_q;
  assign bus.rk_addr = rk_addr_q;

endmodule
